// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C init sequencer.
// Sequencer states, counter width and table entry width.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    WAIT_RDY,
    ISSUE,
    WAIT_ACCEPT,
    WAIT_DONE,
    DELAY,
    NEXT,
    FINISH,
    FAULT
  } state_t;

  localparam logic [7:0] DELAY_REG_DEF = 8'hFF;
  localparam int ENTRY_W = 16;
  localparam int CNT_W = 20;

endpackage

// File: rtl/i2c_init_sequencer_if.sv
// Start/ready handshake between the init sequencer
// and the I2C write master.
interface i2c_init_sequencer_if;

  logic       master_start;
  logic [7:0] master_dev_id;
  logic [7:0] master_reg_id;
  logic [7:0] master_data;
  logic       master_ready;

  modport master (
    output master_start,
    output master_dev_id,
    output master_reg_id,
    output master_data,
    input  master_ready
  );

  modport slave (
    input  master_start,
    input  master_dev_id,
    input  master_reg_id,
    input  master_data,
    output master_ready
  );

endinterface

// File: rtl/i2c_init_rom.sv
// Register-write table: {reg_id, data} per entry.
// One-cycle synchronous read; out-of-range reads give zero.
module i2c_init_rom
  import i2c_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int IDX_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IDX_W-1:0]   addr,
  output logic [ENTRY_W-1:0] q
);

  logic [ENTRY_W-1:0] rd;

  always_comb begin
    rd = '0;
    if (32'(addr) < 32'(NUM_ENTRIES)) begin
      case (32'(addr))
        0:       rd = 16'h10AA;
        1:       rd = 16'h1155;
        2:       rd = 16'hFF03;
        3:       rd = 16'h120F;
        default: rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= rd;
  end

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks the init table and issues one register write per
// entry to the I2C master; delay entries pause instead.
module i2c_init_sequencer
  import i2c_pkg::*;
#(
  parameter int         NUM_ENTRIES    = 4,
  parameter int         IDX_W          = 4,
  parameter logic [7:0] DEV_ID         = 8'h50,
  parameter logic [7:0] DELAY_REG      = DELAY_REG_DEF,
  parameter int         DELAY_UNIT     = 4,
  parameter int         ACCEPT_TIMEOUT = 8,
  parameter int         DONE_TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  i2c_init_sequencer_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [IDX_W-1:0]     index
);

  localparam logic [CNT_W-1:0] ACC_LAST =
    CNT_W'(ACCEPT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DONE_LAST =
    CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_ENTRIES - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [IDX_W-1:0]   idx_n;
  logic [7:0]         reg_q, reg_n;
  logic [7:0]         dat_q, dat_n;
  logic               ph, ph_n;
  logic [ENTRY_W-1:0] rom_q;

  i2c_init_rom #(
    .NUM_ENTRIES(NUM_ENTRIES),
    .IDX_W      (IDX_W)
  ) u_rom (
    .clk  (clk),
    .reset(reset),
    .addr (index),
    .q    (rom_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      index <= '0;
      reg_q <= '0;
      dat_q <= '0;
      ph    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      index <= idx_n;
      reg_q <= reg_n;
      dat_q <= dat_n;
      ph    <= ph_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = index;
    reg_n   = reg_q;
    dat_n   = dat_q;
    ph_n    = 1'b0;
    unique case (state)
      IDLE, FINISH, FAULT: begin
        if (go) begin
          state_n = FETCH;
          idx_n   = '0;
          cnt_n   = '0;
        end
      end
      FETCH: begin
        // first cycle addresses the ROM, second takes its data
        if (!ph) begin
          ph_n = 1'b1;
        end else begin
          reg_n = rom_q[15:8];
          dat_n = rom_q[7:0];
          if (rom_q[15:8] == DELAY_REG) begin
            state_n = DELAY;
            cnt_n   = CNT_W'(rom_q[7:0]) * CNT_W'(DELAY_UNIT);
          end else begin
            state_n = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: begin
        if (bus.master_ready) state_n = ISSUE;
      end
      ISSUE: begin
        state_n = WAIT_ACCEPT;
        cnt_n   = '0;
      end
      WAIT_ACCEPT: begin
        if (!bus.master_ready) begin
          state_n = WAIT_DONE;
          cnt_n   = '0;
        end else if (cnt == ACC_LAST) begin
          state_n = FAULT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (bus.master_ready) begin
          state_n = NEXT;
        end else if (cnt == DONE_LAST) begin
          state_n = FAULT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DELAY: begin
        // a zero-length delay still spends one cycle here
        if (cnt <= CNT_W'(1)) begin
          state_n = NEXT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      NEXT: begin
        if (index == LAST_IDX) begin
          state_n = FINISH;
        end else begin
          state_n = FETCH;
          idx_n   = index + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.master_start  = (state == ISSUE);
  assign bus.master_dev_id = DEV_ID;
  assign bus.master_reg_id = reg_q;
  assign bus.master_data   = dat_q;

  assign done  = (state == FINISH);
  assign error = (state == FAULT);
  assign busy  = (state != IDLE) &&
                 (state != FINISH) &&
                 (state != FAULT);

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Scoreboard bench for the I2C init sequencer with a
// behavioural I2C master model and table-derived timing.
module tb_i2c_init_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic       busy, done, error;
  logic [3:0] index;
  logic       slave_rdy = 1'b1;
  logic       hold_low = 1'b0;
  logic       no_fall = 1'b0;

  i2c_init_sequencer_if bus ();

  assign bus.master_ready = slave_rdy & ~hold_low;

  i2c_init_sequencer dut (
    .clk  (clk),
    .reset(reset),
    .go   (go),
    .bus  (bus),
    .busy (busy),
    .done (done),
    .error(error),
    .index(index)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic [7:0] d;
    int         gap;
    bit         first;
  } exp_t;

  exp_t exp_q[$];
  int   low_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cnt = 0;
  int last_start = -1;
  int last_rise = 0;
  int first_ref = -1;
  int slave_len = 0;
  bit prev_start = 1'b0;
  bit prev_rdy = 1'b1;

  logic [15:0] rom_tbl [4] =
    '{16'h10AA, 16'h1155, 16'hFF03, 16'h120F};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  // Expected writes plus cycle gaps derived from table rules:
  // first start is 4 cycles after go, later starts 5 cycles
  // after ready rises; a delay entry adds 3 + max(d*4,1).
  function automatic int build_expected();
    int         acc;
    int         n;
    bit         first;
    int         dl;
    logic [7:0] r;
    logic [7:0] d;
    acc   = 0;
    n     = 0;
    first = 1'b1;
    foreach (rom_tbl[i]) begin
      r = rom_tbl[i][15:8];
      d = rom_tbl[i][7:0];
      if (r == 8'hFF) begin
        dl  = int'(d) * 4;
        acc += 3 + ((dl > 0) ? dl : 1);
      end else begin
        exp_q.push_back('{r, d,
                          first ? 4 + acc : 5 + acc,
                          first});
        first = 1'b0;
        acc   = 0;
        n++;
      end
    end
    return n;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.master_ready && !prev_rdy) last_rise = cyc;
      prev_rdy = bus.master_ready;
      if (bus.master_start) begin
        chk("start_single_cycle", prev_start, 0);
        chk("dev_id_at_start", bus.master_dev_id, 8'h50);
        start_cnt++;
        last_start = cyc;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_start: reg %0h data %0h",
                   bus.master_reg_id, bus.master_data);
        end else begin
          e = exp_q.pop_front();
          chk("start_reg_id", bus.master_reg_id, e.r);
          chk("start_data", bus.master_data, e.d);
          if (e.first) begin
            if (first_ref >= 0)
              chk("go_to_first_start", cyc - first_ref, e.gap);
          end else begin
            chk("ready_rise_to_start", cyc - last_rise, e.gap);
          end
        end
      end
      prev_start = bus.master_start;
    end
  end

  initial begin : master_model
    forever begin
      @(negedge clk);
      if (bus.master_start && !no_fall) begin
        slave_len = (low_q.size() > 0) ? low_q.pop_front() : 30;
        @(posedge clk);
        #1 slave_rdy = 1'b0;
        repeat (slave_len) @(posedge clk);
        #1 slave_rdy = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_go(output int g);
    @(posedge clk);
    #1 go = 1'b1;
    g = cyc;
    @(posedge clk);
    #1 go = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int lim);
    int k = 0;
    while (start_cnt < n && k < lim) begin
      tick();
      k++;
    end
    chk("start_arrived", start_cnt >= n, 1);
  endtask

  task automatic wait_ready(input int lim);
    int k = 0;
    while (!bus.master_ready && k < lim) begin
      tick();
      k++;
    end
    chk("master_ready_released", bus.master_ready, 1);
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    bit gap = 1'b0;
    while (!done && k < lim) begin
      if (!busy) gap = 1'b1;
      tick();
      k++;
    end
    chk("done_reached", done, 1);
    chk("busy_held_until_done", gap, 0);
    chk("busy_low_at_done", busy, 0);
    chk("index_at_finish", index, 3);
    chk("dev_id_at_finish", bus.master_dev_id, 8'h50);
  endtask

  task automatic run_seq(input int nextra);
    int g, dummy, n, base;
    repeat ($urandom_range(1, 5)) tick();
    n = build_expected();
    for (int i = 0; i < n; i++)
      low_q.push_back($urandom_range(10, 40));
    base = start_cnt;
    pulse_go(g);
    first_ref = g;
    tick();
    chk("busy_after_go", busy, 1);
    chk("error_clear_after_go", error, 0);
    chk("done_clear_after_go", done, 0);
    for (int i = 0; i < nextra; i++) begin
      repeat ($urandom_range(3, 12)) tick();
      pulse_go(dummy);
    end
    wait_done(3000);
    chk("write_count", start_cnt - base, n);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int g, s, h, n, base, dummy;

    repeat (3) @(posedge clk);
    #1;
    tick();
    chk("rst_start", bus.master_start, 0);
    chk("rst_reg_id", bus.master_reg_id, 0);
    chk("rst_data", bus.master_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_index", index, 0);
    chk("rst_dev_id", bus.master_dev_id, 8'h50);
    reset = 1'b0;
    tick();

    run_seq(0);
    run_seq($urandom_range(1, 3));
    run_seq($urandom_range(1, 3));

    n = build_expected();
    base = start_cnt;
    no_fall = 1'b1;
    pulse_go(g);
    first_ref = g;
    wait_starts(base + 1, 50);
    s = last_start;
    while (cyc < s + 8) tick();
    chk("accept_no_fault_yet", error, 0);
    tick();
    chk("accept_timeout_error", error, 1);
    chk("accept_timeout_busy", busy, 0);
    chk("accept_timeout_index", index, 0);
    repeat (20) tick();
    chk("no_start_after_fault", start_cnt - base, 1);
    chk("error_sticky", error, 1);
    exp_q.delete();
    no_fall = 1'b0;
    run_seq(0);

    n = build_expected();
    low_q.push_back(20);
    low_q.push_back(1100);
    base = start_cnt;
    pulse_go(g);
    first_ref = g;
    wait_starts(base + 2, 200);
    s = last_start;
    while (cyc < s + 1025) tick();
    chk("done_no_fault_yet", error, 0);
    tick();
    chk("done_timeout_error", error, 1);
    chk("done_timeout_busy", busy, 0);
    chk("done_timeout_index", index, 1);
    exp_q.delete();
    low_q.delete();
    wait_ready(200);
    chk("done_timeout_writes", start_cnt - base, 2);

    n = build_expected();
    low_q.push_back(15);
    low_q.push_back(30);
    base = start_cnt;
    pulse_go(g);
    first_ref = g;
    wait_starts(base + 2, 200);
    s = last_start;
    while (cyc < s + 10) tick();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    chk("midrst_start", bus.master_start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_error", error, 0);
    chk("midrst_index", index, 0);
    chk("midrst_reg_id", bus.master_reg_id, 0);
    chk("midrst_data", bus.master_data, 0);
    chk("midrst_writes", start_cnt - base, 2);
    exp_q.delete();
    low_q.delete();
    wait_ready(100);
    run_seq(1);

    n = build_expected();
    for (int i = 0; i < n; i++)
      low_q.push_back($urandom_range(10, 40));
    base = start_cnt;
    hold_low = 1'b1;
    pulse_go(g);
    first_ref = -1;
    repeat ($urandom_range(1, 3)) pulse_go(dummy);
    repeat (8) tick();
    chk("wait_rdy_busy", busy, 1);
    chk("no_start_while_not_ready", start_cnt - base, 0);
    @(posedge clk);
    #1 hold_low = 1'b0;
    h = cyc;
    wait_starts(base + 1, 20);
    chk("ready_rise_to_first_start", last_start - h, 1);
    pulse_go(dummy);
    wait_done(3000);
    chk("hold_write_count", start_cnt - base, n);
    chk("hold_scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
